lsnn_neuron_scheduler: RTL

Time-multiplexes `N_NEURONS` adaptive leaky integrate-and-fire neurons onto a single shared update datapath. Per-neuron membrane state, adaptation and input current live in on-block register files. A `start` pulse triggers one timestep sweep that updates every neuron once, in index order, and reports spikes. It sits between the input-current loader and the spike consumer of the LSNN tile.

---
 rtl/lsnn_neuron_scheduler_if.sv | 38 +++
 rtl/lsnn_neuron_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lsnn_neuron_scheduler_if.sv
// ============================================================================
// Module   : lsnn_neuron_scheduler_if
// Purpose  : Control, current-load, spike and observe signals of the LSNN
//            neuron scheduler, with master (driver) and slave (scheduler) views.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface lsnn_neuron_scheduler_if #(
    parameter int N_NEURONS = 4,
    parameter int W         = 8
);
    localparam int IW = $clog2(N_NEURONS);

    logic                 cur_we;
    logic [IW-1:0]        cur_addr;
    logic [W-1:0]         cur_data;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [N_NEURONS-1:0] spike_vec;
    logic                 spk_valid;
    logic [IW-1:0]        spk_idx;
    logic [IW-1:0]        obs_idx;
    logic [W-1:0]         obs_thr;

    modport master (
        output cur_we, cur_addr, cur_data, start, obs_idx,
        input  busy, done, spike_vec, spk_valid, spk_idx, obs_thr
    );

    modport slave (
        input  cur_we, cur_addr, cur_data, start, obs_idx,
        output busy, done, spike_vec, spk_valid, spk_idx, obs_thr
    );
endinterface

`default_nettype wire

// File: rtl/lsnn_neuron_scheduler.sv
// ============================================================================
// Module   : lsnn_neuron_scheduler
// Purpose  : Sweeps N_NEURONS adaptive LIF neurons through one shared update
//            datapath per timestep. Optional LSNN_SCHED_RESET_ON_SPIKE_EN
//            clears the membrane of a neuron that fires.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lsnn_neuron_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int W          = 8,
    parameter int ALPHA_INIT = 8,
    parameter int B0         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lsnn_neuron_scheduler_if.slave  bus
);
    localparam int                IW           = $clog2(N_NEURONS);
    localparam logic [W-1:0]      C_B0         = W'(B0);
    localparam logic [W-1:0]      C_ALPHA_INIT = W'(ALPHA_INIT);
    localparam logic [IW-1:0]     C_LAST       = IW'(N_NEURONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         w_idx_nxt;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_upd;
    logic                  w_clr_shadow;

    logic [W-1:0]          r_s   [N_NEURONS];
    logic [W-1:0]          r_a   [N_NEURONS];
    logic [W-1:0]          r_cur [N_NEURONS];

    logic [W-1:0]          w_s_cur;
    logic [W-1:0]          w_a_cur;
    logic [W-1:0]          w_c_cur;
    logic [W-1:0]          w_thr;
    logic                  w_fire;
    logic [W-1:0]          w_s_int;
    logic [W-1:0]          w_s_nxt;
    logic [W-1:0]          w_a_q;
    logic [W-1:0]          w_a_inc;
    logic [W-1:0]          w_a_nxt;
    logic [N_NEURONS-1:0]  w_shadow_nxt;

    logic [N_NEURONS-1:0]  r_shadow;
    logic [N_NEURONS-1:0]  r_spike_vec;
    logic                  r_spk_valid;
    logic [IW-1:0]         r_spk_idx;
    logic [W-1:0]          r_obs_thr;

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        return sum[W] ? {W{1'b1}} : sum[W-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_upd        = 1'b0;
        w_clr_shadow = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt  = ST_SWEEP;
                    w_idx_nxt    = '0;
                    w_clr_shadow = 1'b1;
                end
            end
            ST_SWEEP: begin
                w_busy    = 1'b1;
                w_upd     = 1'b1;
                w_idx_nxt = r_idx + IW'(1);
                if (r_idx == C_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shared neuron update datapath (pre-update values of neuron r_idx)
    // ------------------------------------------------------------------------
    always_comb begin
        w_s_cur = r_s[r_idx];
        w_a_cur = r_a[r_idx];
        w_c_cur = r_cur[r_idx];
        w_thr   = sat_add(C_B0, w_a_cur);
        w_fire  = (w_s_cur >= w_thr);
        w_s_int = sat_add(w_c_cur, w_s_cur >> 1);
`ifdef LSNN_SCHED_RESET_ON_SPIKE_EN
        w_s_nxt = w_fire ? '0 : w_s_int;
`else
        w_s_nxt = w_s_int;
`endif
        // Adaptation always grows by at least one on a spike, even from zero.
        w_a_q   = w_a_cur >> 2;
        w_a_inc = (w_a_q == '0) ? W'(1) : w_a_q;
        w_a_nxt = w_fire ? sat_add(w_a_cur, w_a_inc)
                         : (w_a_cur >> 1) + (w_a_cur >> 2);
        w_shadow_nxt = r_shadow;
        if (w_upd && w_fire) begin
            w_shadow_nxt = r_shadow | (N_NEURONS'(1) << r_idx);
        end
    end

    // ------------------------------------------------------------------------
    // Register files; a same-cycle current write is seen from the next cycle
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_s[i]   <= '0;
                r_a[i]   <= C_ALPHA_INIT;
                r_cur[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (bus.cur_we && (bus.cur_addr == IW'(i))) begin
                    r_cur[i] <= bus.cur_data;
                end
                if (w_upd && (r_idx == IW'(i))) begin
                    r_s[i] <= w_s_nxt;
                    r_a[i] <= w_a_nxt;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Spike reporting and threshold observation
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_spike_vec <= '0;
            r_spk_valid <= 1'b0;
            r_spk_idx   <= '0;
            r_obs_thr   <= '0;
        end else begin
            if (w_clr_shadow) begin
                r_shadow <= '0;
            end else if (w_upd) begin
                r_shadow <= w_shadow_nxt;
            end
            // Last neuron's bit is merged directly so spike_vec is valid with done.
            if (w_upd && (r_idx == C_LAST)) begin
                r_spike_vec <= w_shadow_nxt;
            end
            r_spk_valid <= w_upd & w_fire;
            if (w_upd && w_fire) begin
                r_spk_idx <= r_idx;
            end
            r_obs_thr <= sat_add(C_B0, r_a[bus.obs_idx]);
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.spike_vec = r_spike_vec;
    assign bus.spk_valid = r_spk_valid;
    assign bus.spk_idx   = r_spk_idx;
    assign bus.obs_thr   = r_obs_thr;

endmodule

`default_nettype wire
